// File: rtl/decode_issue_queue.sv
// decode_issue_queue: merges NUM_SRC format-decoder outputs into one in-order
// FIFO with a valid/ready head, an early stall for the upstream pipeline and a
// selective flush that discards every entry younger than a given major ID.
module decode_issue_queue #(
  parameter int NUM_SRC                 = 3,
  parameter int DEPTH                   = 8,
  parameter int STALL_SLACK             = 2,
  parameter int instructionCounterWidth = 64,
  parameter int PAYLOAD_W               = 200,
  parameter int CNT_W                   = $clog2(DEPTH + 1)
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic [NUM_SRC-1:0]                     srcValid_i,
  input  logic [NUM_SRC*instructionCounterWidth-1:0] srcMajId_i,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]           srcPayload_i,
  input  logic                                   flush_i,
  input  logic [instructionCounterWidth-1:0]     flushMajId_i,
  input  logic                                   ready_i,
  output logic                                   valid_o,
  output logic [instructionCounterWidth-1:0]     majId_o,
  output logic [PAYLOAD_W-1:0]                   payload_o,
  output logic                                   stall_o,
  output logic [CNT_W-1:0]                       count_o,
  output logic                                   multiHotError_o,
  output logic                                   overflowError_o
);

  localparam int IW    = instructionCounterWidth;
  localparam int PTR_W = $clog2(DEPTH);

  // Storage is deliberately not reset; head outputs are only meaningful with valid_o.
  logic [IW-1:0]        id_mem [DEPTH];
  logic [PAYLOAD_W-1:0] pl_mem [DEPTH];

  logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]     count_q, count_d, surv;
  logic                 mh_q, mh_d, ov_q, ov_d;
  logic [IW-1:0]        sel_id;
  logic [PAYLOAD_W-1:0] sel_pl;
  logic                 head_keep, full, pop, push_req, push;

  // Lowest-index valid source wins; source 0 lives in the MSBs of every bus.
  always_comb begin
    sel_id = '0;
    sel_pl = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (srcValid_i[NUM_SRC-1-s]) begin
        sel_id = srcMajId_i[(NUM_SRC-1-s)*IW +: IW];
        sel_pl = srcPayload_i[(NUM_SRC-1-s)*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Entries are in ascending ID order, so counting retained IDs gives the surviving prefix length.
  always_comb begin
    surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (id_mem[rd_q + PTR_W'(i)] <= flushMajId_i))
        surv = surv + 1'b1;
    end
  end

  assign head_keep = !flush_i || (id_mem[rd_q] <= flushMajId_i);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = valid_o && ready_i && head_keep;
  assign push_req  = (|srcValid_i) && !flush_i;
  assign push      = push_req && (!full || pop);

  // Pointer, occupancy and sticky-error next state.
  always_comb begin
    rd_d = rd_q + PTR_W'(pop);
    if (flush_i) begin
      wr_d    = rd_q + surv[PTR_W-1:0];
      count_d = surv - CNT_W'(pop);
    end else begin
      wr_d    = wr_q + PTR_W'(push);
      count_d = count_q - CNT_W'(pop) + CNT_W'(push);
    end
    mh_d = mh_q || ($countones(srcValid_i) > 1);
    ov_d = ov_q || (push_req && full && !pop);
  end

  // Control state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      mh_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      mh_q    <= mh_d;
      ov_q    <= ov_d;
    end
  end

  // Entry write on an accepted push.
  always_ff @(posedge clock_i) begin
    if (push) begin
      id_mem[wr_q] <= sel_id;
      pl_mem[wr_q] <= sel_pl;
    end
  end

  assign valid_o         = (count_q != '0);
  assign majId_o         = id_mem[rd_q];
  assign payload_o       = pl_mem[rd_q];
  assign stall_o         = (count_q >= CNT_W'(DEPTH - STALL_SLACK));
  assign count_o         = count_q;
  assign multiHotError_o = mh_q;
  assign overflowError_o = ov_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_decode_issue_queue;

  localparam int NS = 3;
  localparam int D  = 8;
  localparam int SL = 2;
  localparam int IW = 64;
  localparam int PW = 200;
  localparam int CW = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS*IW-1:0] src_id = '0;
  logic [NS*PW-1:0] src_pl = '0;
  logic             flush = 1'b0;
  logic [IW-1:0]    flush_id = '0;
  logic             ready = 1'b0;
  logic             valid_o, stall_o, mh_o, ov_o;
  logic [IW-1:0]    id_o;
  logic [PW-1:0]    pl_o;
  logic [CW-1:0]    count_o;

  typedef struct {
    logic [IW-1:0] id;
    logic [PW-1:0] pl;
  } entry_t;

  entry_t        mq[$];
  bit            m_mh, m_ov;
  logic [IW-1:0] next_id;
  int            n_checks = 0;
  int            n_fail = 0;

  decode_issue_queue #(
    .NUM_SRC(NS), .DEPTH(D), .STALL_SLACK(SL),
    .instructionCounterWidth(IW), .PAYLOAD_W(PW)
  ) dut (
    .clock_i(clk), .reset_i(rst_n),
    .srcValid_i(src_valid), .srcMajId_i(src_id), .srcPayload_i(src_pl),
    .flush_i(flush), .flushMajId_i(flush_id), .ready_i(ready),
    .valid_o(valid_o), .majId_o(id_o), .payload_o(pl_o), .stall_o(stall_o),
    .count_o(count_o), .multiHotError_o(mh_o), .overflowError_o(ov_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 256'(count_o), 256'(mq.size()));
    chk("valid", 256'(valid_o), 256'(mq.size() != 0));
    chk("stall", 256'(stall_o), 256'((D - mq.size()) <= SL));
    chk("multihot", 256'(mh_o), 256'(m_mh));
    chk("overflow", 256'(ov_o), 256'(m_ov));
    if (mq.size() != 0) begin
      chk("head_id", 256'(id_o), 256'(mq[0].id));
      chk("head_payload", 256'(pl_o), 256'(mq[0].pl));
    end
  endtask

  task automatic rand_pl(output logic [PW-1:0] p);
    p = '0;
    for (int k = 0; k < 7; k++) p = {p[PW-33:0], 32'($urandom())};
  endtask

  // One clock: drive inputs, advance model on the edge, check 1 time unit later.
  task automatic step(input logic [NS-1:0] v, input bit rdy, input bit fl, input logic [IW-1:0] fid);
    logic [PW-1:0] p;
    entry_t        e;
    bit            have, pop;
    entry_t        keep[$];
    have = 1'b0;
    e.id = '0;
    e.pl = '0;
    src_valid = v;
    ready     = rdy;
    flush     = fl;
    flush_id  = fid;
    for (int s = 0; s < NS; s++) begin
      rand_pl(p);
      src_pl[(NS-1-s)*PW +: PW] = p;
      if (v[NS-1-s] && !have) begin
        have = 1'b1;
        src_id[(NS-1-s)*IW +: IW] = next_id;
        e.id = next_id;
        e.pl = p;
        next_id = next_id + 64'd1;
      end else begin
        src_id[(NS-1-s)*IW +: IW] = {32'($urandom()), 32'($urandom())};
      end
    end
    @(posedge clk);
    pop = (mq.size() != 0) && rdy && (!fl || mq[0].id <= fid);
    if (fl) begin
      foreach (mq[i]) if (mq[i].id <= fid) keep.push_back(mq[i]);
      mq = keep;
      if (pop) void'(mq.pop_front());
    end else begin
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < D) mq.push_back(e);
        else m_ov = 1'b1;
      end
    end
    if ($countones(v) > 1) m_mh = 1'b1;
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    src_valid = '0;
    flush     = 1'b0;
    ready     = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] fid;
    logic [IW-1:0] head;
    m_mh = 1'b0;
    m_ov = 1'b0;
    next_id = 64'd1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 256'(valid_o), 256'(0));
    chk("rst_count", 256'(count_o), 256'(0));
    chk("rst_stall", 256'(stall_o), 256'(0));
    chk("rst_errors", 256'({mh_o, ov_o}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fill IDs 1..8 from source 1, no pops
    repeat (8) step(3'b010, 1'b0, 1'b0, '0);
    chk("fill_count", 256'(count_o), 256'(8));
    chk("fill_stall", 256'(stall_o), 256'(1));

    // Full with simultaneous push/pop, then push while full
    step(3'b010, 1'b1, 1'b0, '0);
    chk("full_pushpop_count", 256'(count_o), 256'(8));
    chk("full_pushpop_ovf", 256'(ov_o), 256'(0));
    step(3'b010, 1'b0, 1'b0, '0);
    chk("full_push_ovf", 256'(ov_o), 256'(1));
    repeat (9) step(3'b000, 1'b1, 1'b0, '0);
    chk("drained", 256'(valid_o), 256'(0));

    // Multi-hot: sources 1 and 2 together, source 1 wins
    next_id = 64'd20;
    step(3'b011, 1'b0, 1'b0, '0);
    chk("multihot_id", 256'(id_o), 256'(20));
    chk("multihot_flag", 256'(mh_o), 256'(1));
    step(3'b000, 1'b1, 1'b0, '0);

    // Flush keeping <= 32 with head popping and an incoming instruction
    next_id = 64'd30;
    repeat (6) step(3'b100, 1'b0, 1'b0, '0);
    step(3'b001, 1'b1, 1'b1, 64'd32);
    chk("flush_count", 256'(count_o), 256'(2));
    chk("flush_head", 256'(id_o), 256'(31));
    repeat (3) step(3'b000, 1'b1, 1'b0, '0);
    chk("flush_empty", 256'(valid_o), 256'(0));
    chk("flush_no_ovf_change", 256'(ov_o), 256'(1));

    // Asynchronous reset mid-stream
    repeat (4) step(3'b001, 1'b0, 1'b0, '0);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_mh = 1'b0;
    m_ov = 1'b0;
    chk("arst_valid", 256'(valid_o), 256'(0));
    chk("arst_count", 256'(count_o), 256'(0));
    chk("arst_stall", 256'(stall_o), 256'(0));
    chk("arst_errors", 256'({mh_o, ov_o}), 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(3'b100, 1'b0, 1'b0, '0);
    chk("post_rst_push", 256'(count_o), 256'(1));
    step(3'b000, 1'b1, 1'b0, '0);

    // Move read pointer to 6, hold 5 entries across the wrap, flush all
    repeat (5) step(3'b010, 1'b0, 1'b0, '0);
    repeat (5) step(3'b000, 1'b1, 1'b0, '0);
    repeat (5) step(3'b010, 1'b0, 1'b0, '0);
    head = next_id - 64'd5;
    step(3'b000, 1'b0, 1'b1, head - 64'd1);
    chk("wrap_flush_count", 256'(count_o), 256'(0));
    step(3'b001, 1'b0, 1'b0, '0);
    chk("wrap_next_id", 256'(id_o), 256'(next_id - 64'd1));
    chk("wrap_next_count", 256'(count_o), 256'(1));
    step(3'b000, 1'b1, 1'b0, '0);

    // Random traffic
    next_id = 64'd1000;
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] v;
      bit            fl;
      v  = ($urandom_range(0, 9) < 6) ? NS'($urandom_range(1, (1 << NS) - 1)) : '0;
      fl = ($urandom_range(0, 15) == 0);
      fid = next_id - 64'(1 + $urandom_range(0, 9));
      step(v, bit'($urandom_range(0, 1)), fl, fid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
